pu_riscv_wb_mmio_master: RTL and testbench

Wishbone B3 bus initiator that turns a simple command/write-data stream into single or incrementing-burst Wishbone cycles and returns read data and completion status. It is the master-side counterpart to the test bench's Wishbone MMIO responder models: it drives host-side accesses such as tohost polling, UART-TX writes and memory preload, and it also serves as a synthesizable debug-bus master. The bus is 32-bit, with one outstanding command at a time.

---
 rtl/pu_riscv_wb_pkg.sv | 24 ++
 rtl/pu_riscv_wb_timeout.sv | 36 +++
 rtl/pu_riscv_wb_mmio_master.sv | 218 +++++++++++++++++++++
 tb/tb_pu_riscv_wb_mmio_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_wb_pkg.sv
// Shared constants and enums for the Wishbone MMIO master: cycle type identifiers,
// burst type, FSM states and command completion status codes.
package pu_riscv_wb_pkg;

  localparam logic [2:0] CLASSIC    = 3'b000;
  localparam logic [2:0] INCR       = 3'b010;
  localparam logic [2:0] EOB        = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WDATA = 2'b01,
    BUS   = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_ERR     = 2'b01,
    STAT_RTY     = 2'b10,
    STAT_TIMEOUT = 2'b11
  } status_e;

endpackage

// File: rtl/pu_riscv_wb_timeout.sv
// Per-beat watchdog: counts cycles while enabled, restarts on clear, and flags
// when the count has reached TIMEOUT.
module pu_riscv_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/pu_riscv_wb_mmio_master.sv
// Wishbone B3 initiator: turns one command plus per-beat write data into a single
// or incrementing-burst bus cycle and reports read data and completion status.
module pu_riscv_wb_mmio_master
  import pu_riscv_wb_pkg::*;
#(
  parameter int HADDR_SIZE   = 32,
  parameter int HDATA_SIZE   = 32,
  parameter int MAX_LEN_BITS = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [HADDR_SIZE-1:0]     cmd_adr,
  input  logic                      cmd_we,
  input  logic [HDATA_SIZE/8-1:0]   cmd_sel,
  input  logic [MAX_LEN_BITS-1:0]   cmd_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [HDATA_SIZE-1:0]     wr_dat,
  output logic                      rsp_valid,
  output logic [HDATA_SIZE-1:0]     rsp_dat,
  output logic                      done,
  output logic [1:0]                done_status,
  output logic [HADDR_SIZE-1:0]     wb_adr_o,
  output logic [HDATA_SIZE-1:0]     wb_dat_o,
  output logic [HDATA_SIZE/8-1:0]   wb_sel_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic [2:0]                wb_cti_o,
  output logic [1:0]                wb_bte_o,
  input  logic [HDATA_SIZE-1:0]     wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);

  localparam int LANES = HDATA_SIZE / 8;

  state_e                  state_q, state_d;
  status_e                 status_q, status_d;
  logic [HADDR_SIZE-1:0]   adr_q, adr_d;
  logic [HDATA_SIZE-1:0]   dat_q, dat_d;
  logic [LANES-1:0]        sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic [2:0]              cti_q, cti_d;
  logic [MAX_LEN_BITS-1:0] beats_q, beats_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [HDATA_SIZE-1:0]   rsp_dat_q, rsp_dat_d;
  logic                    done_q, done_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    wr_ready_q, wr_ready_d;

  logic    beat_end;
  logic    expired;
  logic    finish;
  status_e fin_status;

  assign beat_end = stb_q && (wb_ack_i || wb_err_i || wb_rty_i);

  pu_riscv_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (HCLK),
    .rst     (HRESET),
    .clear   ((state_q != BUS) || beat_end),
    .enable  (state_q == BUS),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    cti_d       = cti_q;
    beats_d     = beats_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    done_d      = 1'b0;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = wr_ready_q;
    finish      = 1'b0;
    fin_status  = STAT_OK;

    unique case (state_q)
      // DONE accepts a new command like IDLE so back-to-back commands lose no cycle.
      IDLE, DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          adr_d       = cmd_adr;
          we_d        = cmd_we;
          sel_d       = cmd_sel;
          beats_d     = cmd_len;
          cti_d       = (cmd_len == '0) ? CLASSIC : INCR;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          if (cmd_we) begin
            state_d    = WDATA;
            wr_ready_d = 1'b1;
            stb_d      = 1'b0;
          end else begin
            state_d = BUS;
            stb_d   = 1'b1;
          end
        end
      end
      WDATA: begin
        if (wr_valid) begin
          dat_d      = wr_dat;
          wr_ready_d = 1'b0;
          stb_d      = 1'b1;
          state_d    = BUS;
        end
      end
      BUS: begin
        if (stb_q && wb_err_i) begin
          finish     = 1'b1;
          fin_status = STAT_ERR;
        end else if (stb_q && wb_rty_i) begin
          finish     = 1'b1;
          fin_status = STAT_RTY;
        end else if (stb_q && wb_ack_i) begin
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = wb_dat_i;
          end
          if (beats_q != '0) begin
            adr_d   = adr_q + HADDR_SIZE'(LANES);
            beats_d = beats_q - MAX_LEN_BITS'(1);
            cti_d   = (beats_q == MAX_LEN_BITS'(1)) ? EOB : INCR;
            if (we_q) begin
              state_d    = WDATA;
              stb_d      = 1'b0;
              wr_ready_d = 1'b1;
            end
          end else begin
            finish = 1'b1;
          end
        end else if (expired) begin
          finish     = 1'b1;
          fin_status = STAT_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d     = DONE;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      done_d      = 1'b1;
      status_d    = fin_status;
      cmd_ready_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      status_q    <= STAT_OK;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cti_q       <= CLASSIC;
      beats_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      cti_q       <= cti_d;
      beats_q     <= beats_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wr_ready    = wr_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign done        = done_q;
  assign done_status = status_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_cti_o    = cti_q;
  assign wb_bte_o    = BTE_LINEAR;

endmodule

// File: tb/tb_pu_riscv_wb_mmio_master.sv
// Bench for the Wishbone MMIO master: a scripted slave, a transaction-level model of
// the expected bus beats, responses and completion, and directed scenarios.
module tb_pu_riscv_wb_mmio_master;

  localparam int TO_CYCLES = 256;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_we, wr_valid;
  logic [31:0] cmd_adr, wr_dat;
  logic [3:0]  cmd_sel;
  logic [2:0]  cmd_len;
  logic        cmd_ready, wr_ready, rsp_valid, done;
  logic [31:0] rsp_dat;
  logic [1:0]  done_status;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  int tests_run = 0;
  int tests_failed = 0;

  // slave script
  int          sl_waits, sl_fault_beat, sl_beat, sl_cnt;
  logic [1:0]  sl_fault_kind;
  bit          sl_noresp, sl_spurious;
  logic [31:0] sl_rdata [8];

  // expected command and model bookkeeping
  logic [31:0] ex_adr;
  bit          ex_we;
  logic [3:0]  ex_sel;
  int          ex_len;
  logic [31:0] ex_wdat [8];
  bit          mdl_en;
  int          mdl_beat, mdl_wait, cyc_no, hs_cycle;
  bit          exp_rsp, exp_done, exp_stb_low;
  logic [31:0] exp_rsp_dat;
  logic [1:0]  exp_status;
  int          rsp_count, done_count, stb_cycles, first_rsp_cycle, last_rsp_cycle, done_cycle;
  logic [31:0] last_rsp_dat;
  logic [1:0]  last_status;
  logic [31:0] obs_adr [8];
  logic [2:0]  obs_cti [8];

  pu_riscv_wb_mmio_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .done(done), .done_status(done_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // slave: terminates a beat after sl_waits stalled cycles, faults on a chosen beat
  always @(negedge HCLK) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (HRESET) begin
      sl_cnt  = 0;
      sl_beat = 0;
    end else if (wb_stb_o && wb_cyc_o) begin
      if (!sl_noresp && sl_cnt == sl_waits) begin
        sl_cnt   = 0;
        wb_ack_i = 1'b1;
        wb_dat_i = sl_rdata[sl_beat % 8];
        if (sl_beat == sl_fault_beat) begin
          wb_err_i = sl_fault_kind[0];
          wb_rty_i = sl_fault_kind[1];
        end
        sl_beat++;
      end else begin
        sl_cnt++;
      end
    end else begin
      sl_cnt = 0;
      if (sl_spurious && wb_cyc_o) wb_ack_i = 1'b1;
    end
  end

  // model + compare: checks registered outputs against expectations set last cycle
  always begin
    @(negedge HCLK);
    #1;
    cyc_no++;
    if (mdl_en) begin
      check_output("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp) begin
        check_output("rsp_dat", rsp_dat, exp_rsp_dat);
        rsp_count++;
        last_rsp_dat = rsp_dat;
        last_rsp_cycle = cyc_no;
        if (first_rsp_cycle < 0) first_rsp_cycle = cyc_no;
      end
      check_output("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        check_output("done_status", 32'(done_status), 32'(exp_status));
        check_output("cyc_after_end", 32'(wb_cyc_o), 32'(1'b0));
        check_output("stb_after_end", 32'(wb_stb_o), 32'(1'b0));
        check_output("cmd_ready_in_done", 32'(cmd_ready), 32'(1'b1));
        done_count++;
        last_status = done_status;
        done_cycle = cyc_no;
      end
      if (exp_stb_low) begin
        check_output("stb_low_wdata", 32'(wb_stb_o), 32'(1'b0));
        check_output("wr_ready_wdata", 32'(wr_ready), 32'(1'b1));
      end
      exp_rsp = 1'b0;
      exp_done = 1'b0;
      exp_stb_low = 1'b0;
      if (wb_stb_o) begin
        stb_cycles++;
        mdl_wait++;
        if (mdl_beat > ex_len || mdl_beat > 7) begin
          tests_failed++;
          $display("[TB] FAIL extra_beat: beat %0d seen, only %0d expected", mdl_beat, ex_len + 1);
        end else begin
          check_output("adr", wb_adr_o, ex_adr + 32'(4 * mdl_beat));
          check_output("cyc", 32'(wb_cyc_o), 32'(1'b1));
          check_output("we", 32'(wb_we_o), 32'(ex_we));
          check_output("sel", 32'(wb_sel_o), 32'(ex_sel));
          check_output("bte", 32'(wb_bte_o), 32'(2'b00));
          check_output("cti", 32'(wb_cti_o),
                       (ex_len == 0) ? 32'h0 : ((mdl_beat == ex_len) ? 32'h7 : 32'h2));
          if (ex_we) check_output("dat_o", wb_dat_o, ex_wdat[mdl_beat]);
          if (wb_ack_i || wb_err_i || wb_rty_i) begin
            obs_adr[mdl_beat] = wb_adr_o;
            obs_cti[mdl_beat] = wb_cti_o;
            mdl_wait = 0;
            if (wb_err_i) begin
              exp_done = 1'b1;
              exp_status = 2'b01;
            end else if (wb_rty_i) begin
              exp_done = 1'b1;
              exp_status = 2'b10;
            end else begin
              if (!ex_we) begin
                exp_rsp = 1'b1;
                exp_rsp_dat = sl_rdata[mdl_beat];
              end
              if (mdl_beat == ex_len) begin
                exp_done = 1'b1;
                exp_status = 2'b00;
              end else if (ex_we) begin
                exp_stb_low = 1'b1;
              end
              mdl_beat++;
            end
          end else if (mdl_wait == TO_CYCLES) begin
            exp_done = 1'b1;
            exp_status = 2'b11;
          end
        end
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] adr, input bit we, input logic [3:0] sel, input int len);
    int k;
    cmd_adr = adr;
    cmd_we = we;
    cmd_sel = sel;
    cmd_len = 3'(len);
    cmd_valid = 1'b1;
    for (k = 0; k < 20 && !cmd_ready; k++) begin
      @(posedge HCLK);
      #2;
    end
    check_output("cmd_ready_wait", 32'(cmd_ready), 32'(1'b1));
    @(posedge HCLK);
    #2;
    cmd_valid = 1'b0;
    hs_cycle = cyc_no;
  endtask

  task automatic apply_stimulus(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                                input int len, input int waits, input int fault_beat,
                                input logic [1:0] fault_kind, input bit noresp, input bit spurious);
    ex_adr = adr;
    ex_we = we;
    ex_sel = sel;
    ex_len = len;
    sl_waits = waits;
    sl_fault_beat = fault_beat;
    sl_fault_kind = fault_kind;
    sl_noresp = noresp;
    sl_spurious = spurious;
    sl_beat = 0;
    sl_cnt = 0;
    mdl_beat = 0;
    mdl_wait = 0;
    rsp_count = 0;
    done_count = 0;
    stb_cycles = 0;
    first_rsp_cycle = -1;
    last_rsp_cycle = -1;
    done_cycle = -1;
    issue_cmd(adr, we, sel, len);
    if (we) begin
      for (int i = 0; i <= len; i++) begin
        for (int k = 0; k < 50 && !wr_ready; k++) begin
          @(posedge HCLK);
          #2;
        end
        check_output("wr_ready_wait", 32'(wr_ready), 32'(1'b1));
        repeat ((i + 2) % 3) begin
          @(posedge HCLK);
          #2;
        end
        wr_valid = 1'b1;
        wr_dat = ex_wdat[i];
        @(posedge HCLK);
        #2;
        wr_valid = 1'b0;
      end
    end
    for (int k = 0; k < 400 && done_count == 0; k++) begin
      @(posedge HCLK);
      #2;
    end
    check_output("done_seen", 32'(done_count), 32'd1);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_dat = '0; wb_dat_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    sl_waits = 0; sl_fault_beat = -1; sl_fault_kind = 2'b00; sl_noresp = 1'b0;
    sl_spurious = 1'b0; sl_beat = 0; sl_cnt = 0;
    mdl_en = 1'b0; cyc_no = 0; exp_rsp = 0; exp_done = 0; exp_stb_low = 0;
    ex_len = 0; ex_we = 0; ex_adr = '0; ex_sel = '0;
    for (int i = 0; i < 8; i++) begin
      sl_rdata[i] = '0;
      ex_wdat[i] = '0;
    end
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #2;
    check_output("rst_cyc", 32'(wb_cyc_o), 32'(1'b0));
    check_output("rst_stb", 32'(wb_stb_o), 32'(1'b0));
    check_output("rst_we", 32'(wb_we_o), 32'(1'b0));
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    check_output("rst_done", 32'(done), 32'(1'b0));
    check_output("rst_wr_ready", 32'(wr_ready), 32'(1'b0));
    check_output("rst_adr", wb_adr_o, 32'h0);
    check_output("rst_dat_o", wb_dat_o, 32'h0);
    check_output("rst_sel", 32'(wb_sel_o), 32'h0);
    check_output("rst_cti", 32'(wb_cti_o), 32'h0);
    check_output("rst_rsp_dat", rsp_dat, 32'h0);
    check_output("rst_status", 32'(done_status), 32'h0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'(1'b1));
    HRESET = 1'b0;
    mdl_en = 1'b1;

    // single read, two wait states
    sl_rdata[0] = 32'h0000_0001;
    apply_stimulus(32'h8000_1000, 1'b0, 4'hF, 0, 2, -1, 2'b00, 1'b0, 1'b0);
    check_output("t1_rsp_count", 32'(rsp_count), 32'd1);
    check_output("t1_rsp_dat", last_rsp_dat, 32'h0000_0001);
    check_output("t1_status", 32'(last_status), 32'h0);
    check_output("t1_rsp_with_done", 32'(last_rsp_cycle), 32'(done_cycle));
    check_output("t1_cti", 32'(obs_cti[0]), 32'h0);

    // zero-wait single read: done two cycles after the handshake cycle
    sl_rdata[0] = 32'hDEAD_BEEF;
    apply_stimulus(32'h1000_0040, 1'b0, 4'hF, 0, 0, -1, 2'b00, 1'b0, 1'b0);
    check_output("t2_latency", 32'(done_cycle - hs_cycle), 32'd2);
    check_output("t2_rsp_dat", last_rsp_dat, 32'hDEAD_BEEF);

    // gapped write burst, slave throws stray acks while stb is low
    for (int i = 0; i < 4; i++) ex_wdat[i] = 32'hA0 + 32'(i);
    apply_stimulus(32'h8000_0000, 1'b1, 4'hF, 3, 1, -1, 2'b00, 1'b0, 1'b1);
    check_output("t3_adr0", obs_adr[0], 32'h8000_0000);
    check_output("t3_adr1", obs_adr[1], 32'h8000_0004);
    check_output("t3_adr2", obs_adr[2], 32'h8000_0008);
    check_output("t3_adr3", obs_adr[3], 32'h8000_000C);
    check_output("t3_cti2", 32'(obs_cti[2]), 32'h2);
    check_output("t3_cti3", 32'(obs_cti[3]), 32'h7);
    check_output("t3_status", 32'(last_status), 32'h0);
    check_output("t3_rsp_count", 32'(rsp_count), 32'd0);

    // read burst wrapping the top of the address space
    for (int i = 0; i < 8; i++) sl_rdata[i] = 32'h100 + 32'(i);
    apply_stimulus(32'hFFFF_FFF8, 1'b0, 4'hF, 7, 0, -1, 2'b00, 1'b0, 1'b0);
    check_output("t4_adr1", obs_adr[1], 32'hFFFF_FFFC);
    check_output("t4_adr2", obs_adr[2], 32'h0000_0000);
    check_output("t4_adr7", obs_adr[7], 32'h0000_0014);
    check_output("t4_rsp_count", 32'(rsp_count), 32'd8);
    check_output("t4_back_to_back", 32'(last_rsp_cycle - first_rsp_cycle), 32'd7);
    check_output("t4_last_rsp", last_rsp_dat, 32'h107);
    check_output("t4_rsp_with_done", 32'(last_rsp_cycle), 32'(done_cycle));

    // err+rty(+ack) together on the second beat
    apply_stimulus(32'h2000_0000, 1'b0, 4'hF, 3, 0, 1, 2'b11, 1'b0, 1'b0);
    check_output("t5_status", 32'(last_status), 32'h1);
    check_output("t5_rsp_count", 32'(rsp_count), 32'd1);

    // retry on the first beat of a burst
    apply_stimulus(32'h2000_0100, 1'b0, 4'hF, 1, 1, 0, 2'b10, 1'b0, 1'b0);
    check_output("t6_status", 32'(last_status), 32'h2);
    check_output("t6_rsp_count", 32'(rsp_count), 32'd0);

    // silent slave
    apply_stimulus(32'h3000_0000, 1'b0, 4'hF, 0, 0, -1, 2'b00, 1'b1, 1'b0);
    check_output("t7_status", 32'(last_status), 32'h3);
    check_output("t7_stb_cycles", 32'(stb_cycles), 32'd256);

    // reset in the middle of a read burst
    mdl_en = 1'b0;
    sl_noresp = 1'b0; sl_waits = 3; sl_fault_beat = -1; sl_beat = 0; sl_cnt = 0;
    issue_cmd(32'h4000_0000, 1'b0, 4'hF, 7);
    for (int k = 0; k < 10 && !wb_stb_o; k++) begin
      @(posedge HCLK);
      #2;
    end
    repeat (6) begin
      @(posedge HCLK);
      #2;
    end
    check_output("t8_stb_before_reset", 32'(wb_stb_o), 32'(1'b1));
    HRESET = 1'b1;
    @(posedge HCLK);
    #2;
    check_output("t8_cyc_reset", 32'(wb_cyc_o), 32'(1'b0));
    check_output("t8_stb_reset", 32'(wb_stb_o), 32'(1'b0));
    HRESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_output("t8_no_done", 32'(done), 32'(1'b0));
      check_output("t8_cmd_ready", 32'(cmd_ready), 32'(1'b1));
      @(posedge HCLK);
      #2;
    end
    exp_rsp = 1'b0; exp_done = 1'b0; exp_stb_low = 1'b0;
    mdl_en = 1'b1;

    // recovery: partial-lane single write
    ex_wdat[0] = 32'h1234_5678;
    apply_stimulus(32'h0000_0004, 1'b1, 4'h3, 0, 0, -1, 2'b00, 1'b0, 1'b0);
    check_output("t9_status", 32'(last_status), 32'h0);
    check_output("t9_adr", obs_adr[0], 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
